// File: rtl/universal_shift_engine.sv
// Multi-cycle universal shift register: parallel load, then N single-bit shifts
// (logical/arithmetic/rotate/serial fill) under a start/busy/done handshake.
module universal_shift_engine #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             start,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             shift_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic             so_q, so_d;
  logic             busy_q, done_q;

  logic             out_bit;
  logic             fill_bit;
  logic [WIDTH-1:0] shifted;

  // Single-bit shift datapath driven only by the latched operation fields
  always_comb begin
    out_bit  = dir_q ? q_q[0] : q_q[WIDTH-1];
    fill_bit = 1'b0;
    case (mode_q)
      MODE_LOG: fill_bit = 1'b0;
      MODE_ARI: fill_bit = dir_q ? q_q[WIDTH-1] : 1'b0;
      MODE_ROT: fill_bit = out_bit;
      default:  fill_bit = ser_in;
    endcase
    shifted = dir_q ? {fill_bit, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], fill_bit};
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    so_d    = so_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          q_d = parallel_in;
        end else if (start) begin
          dir_d   = dir;
          mode_d  = mode;
          rem_d   = amount;
          state_d = (amount == CNT_W'(0)) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        q_d   = shifted;
        so_d  = out_bit;
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered copies of the next state so they align with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
      so_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      so_q    <= so_d;
      busy_q  <= (state_d == SHIFT);
      done_q  <= (state_d == DONE);
    end
  end

  assign q         = q_q;
  assign shift_out = so_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_universal_shift_engine.sv
// Self-checking bench for universal_shift_engine: vector table plus scoreboard,
// with hand-written sequences for ignore, load priority and mid-operation reset.
module tb_universal_shift_engine;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] parallel_in;
  logic             start;
  logic             dir;
  logic [1:0]       mode;
  logic [CNT_W-1:0] amount;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             shift_out;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  universal_shift_engine #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .parallel_in (parallel_in),
    .start       (start),
    .dir         (dir),
    .mode        (mode),
    .amount      (amount),
    .ser_in      (ser_in),
    .q           (q),
    .shift_out   (shift_out),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             do_load;
    logic [WIDTH-1:0] load_val;
    logic             d;
    logic [1:0]       m;
    logic [CNT_W-1:0] amt;
    logic             s;
    logic [WIDTH-1:0] exp_q;
    logic             exp_so;
    int               exp_cyc;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             so;
    int               cyc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: bit-serial shift straight from the operation description
  function automatic exp_t model(input logic [WIDTH-1:0] v, input logic so_in, input logic d,
                                 input logic [1:0] m, input logic [CNT_W-1:0] a, input logic s);
    exp_t r;
    logic o, f;
    r.q = v; r.so = so_in; r.cyc = int'(a);
    for (int i = 0; i < int'(a); i++) begin
      o = d ? r.q[0] : r.q[WIDTH-1];
      case (m)
        2'b00: f = 1'b0;
        2'b01: f = d ? r.q[WIDTH-1] : 1'b0;
        2'b10: f = o;
        default: f = s;
      endcase
      r.q  = d ? {f, r.q[WIDTH-1:1]} : {r.q[WIDTH-2:0], f};
      r.so = o;
    end
    return r;
  endfunction

  // Optional load, then start; scrambles op inputs (and optionally load/start) while busy
  task automatic run_op(input vec_t v, input bit disturb, input string tag);
    exp_t e;
    int   cyc;
    bit   got;
    if (v.do_load) begin
      @(negedge clk);
      load = 1'b1; parallel_in = v.load_val;
      @(negedge clk);
      load = 1'b0;
    end else begin
      @(negedge clk);
    end
    start = 1'b1; dir = v.d; mode = v.m; amount = v.amt; ser_in = v.s;
    e.q = v.exp_q; e.so = v.exp_so; e.cyc = v.exp_cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    cyc = 0; got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      check({tag, "_busy_and_done"}, {31'd0, busy & done}, 32'd0);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) cyc++;
      dir    = 1'($urandom);
      mode   = 2'($urandom);
      amount = CNT_W'($urandom);
      if (disturb) begin
        load = 1'b1; start = 1'b1; parallel_in = 8'hFF;
      end
      @(negedge clk);
    end
    load = 1'b0; start = 1'b0;
    check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    e = sb.pop_front();
    check({tag, "_q"}, {24'd0, q}, {24'd0, e.q});
    check({tag, "_shift_out"}, {31'd0, shift_out}, {31'd0, e.so});
    check({tag, "_busy_cycles"}, cyc, e.cyc);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  vec_t vecs[7];
  vec_t rv;
  exp_t me;
  int   act_cnt;

  initial begin
    reset = 1'b1; load = 1'b0; parallel_in = '0; start = 1'b0;
    dir = 1'b0; mode = 2'b00; amount = '0; ser_in = 1'b0;

    vecs[0] = '{1'b1, 8'hB4, 1'b0, 2'b00, 4'd3,  1'b0, 8'hA0, 1'b1, 3};
    vecs[1] = '{1'b1, 8'h96, 1'b1, 2'b01, 4'd2,  1'b0, 8'hE5, 1'b1, 2};
    vecs[2] = '{1'b1, 8'h81, 1'b0, 2'b10, 4'd11, 1'b0, 8'h0C, 1'b0, 11};
    vecs[3] = '{1'b1, 8'h00, 1'b1, 2'b11, 4'd4,  1'b1, 8'hF0, 1'b0, 4};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 2'b00, 4'd0,  1'b0, 8'hF0, 1'b0, 0};
    vecs[5] = '{1'b1, 8'h5A, 1'b1, 2'b00, 4'd15, 1'b0, 8'h00, 1'b0, 15};
    vecs[6] = '{1'b1, 8'hC3, 1'b0, 2'b01, 4'd1,  1'b0, 8'h86, 1'b1, 1};

    repeat (2) @(negedge clk);
    check("reset_q", {24'd0, q}, 32'd0);
    check("reset_shift_out", {31'd0, shift_out}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) run_op(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Randomised operations against the reference model
    for (int i = 0; i < 8; i++) begin
      rv.do_load  = 1'b1;
      rv.load_val = 8'($urandom);
      rv.d        = 1'($urandom);
      rv.m        = 2'($urandom);
      rv.amt      = CNT_W'($urandom);
      rv.s        = 1'($urandom);
      me = model(rv.load_val, shift_out, rv.d, rv.m, rv.amt, rv.s);
      rv.exp_q = me.q; rv.exp_so = me.so; rv.exp_cyc = me.cyc;
      run_op(rv, 1'b0, $sformatf("rand%0d", i));
    end

    // load/start during SHIFT are ignored
    run_op(vecs[0], 1'b1, "ignore_in_shift");

    // load beats a simultaneous start in IDLE
    @(negedge clk);
    load = 1'b1; start = 1'b1; parallel_in = 8'h3C; amount = 4'd2; dir = 1'b0; mode = 2'b00;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    check("load_prio_q", {24'd0, q}, 32'h3C);
    check("load_prio_shift_out", {31'd0, shift_out}, 32'd1);
    act_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy || done) act_cnt++;
      @(negedge clk);
    end
    check("load_prio_no_busy_done", act_cnt, 0);

    // Reset during shift cycle 2 of an amount=5 operation
    load = 1'b1; parallel_in = 8'hB4;
    @(negedge clk);
    load = 1'b0; start = 1'b1; dir = 1'b0; mode = 2'b00; amount = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_reset_q", {24'd0, q}, 32'hD0);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("midreset_q", {24'd0, q}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_shift_out", {31'd0, shift_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    act_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy || done) act_cnt++;
      @(negedge clk);
    end
    check("after_reset_no_done", act_cnt, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
